uart_tx_queue: RTL and testbench

- Byte FIFO plus launch controller that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer (CPU or bus bridge) at any rate.
- Drives the UART's transmit/tx_byte pair using the full transmit handshake: raise transmit, wait for is_transmitting, drop transmit, wait for idle.
- Ensures one UART frame per queued byte and no repeated characters.

---
 rtl/uart_tx_queue.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus launch controller sitting directly upstream
// of a UART transmitter.
//
// Optional feature macro: UART_TX_QUEUE_LEVEL_EN adds the registered 'level'
// output (current FIFO occupancy). Without it the port is absent.
//
// Handshakes:
//   producer side - a byte is taken on every rising clk edge where
//     wr_en && !full && !flush (full is the registered flag, so a write while
//     full is dropped and overflow pulses even if a pop happens that cycle).
//   UART side - uart_transmit is raised with uart_tx_byte stable and held
//     until uart_is_transmitting is seen high; it then drops and the head is
//     popped. The next launch waits until uart_is_transmitting returns low.
//     If no acknowledge arrives within ACK_TIMEOUT cycles the launch is
//     abandoned (ack_timeout pulses) and the head is retried.
//
// The controller state is held in the enum signal 'state' (IDLE, LAUNCH,
// WAIT_DONE) so checkers can bind to it by name.
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       ack_timeout,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic [TW-1:0]   timer, timer_n;
  logic            wr_accept;
  logic            pop;
  logic            transmit_n;
  logic [7:0]      byte_n;
  logic            timeout_n;

  assign wr_accept = wr_en && !full && !flush;

`ifdef UART_TX_QUEUE_LEVEL_EN
  assign level = count;
`endif

  // Next FIFO occupancy: flush wins, simultaneous write and pop cancel out.
  always_comb begin
    count_n = count;
    if (flush)
      count_n = '0;
    else if (wr_accept && !pop)
      count_n = count + CW'(1);
    else if (!wr_accept && pop)
      count_n = count - CW'(1);
  end

  // Storage array; only written on accepted writes, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered full/empty/overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      count    <= count_n;
      full     <= (count_n == CW'(DEPTH));
      empty    <= (count_n == '0);
      overflow <= wr_en && full && !flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Launch controller next state and next registered output values.
  always_comb begin
    state_n    = state;
    transmit_n = uart_transmit;
    byte_n     = uart_tx_byte;
    timer_n    = timer;
    timeout_n  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !uart_is_transmitting && !flush) begin
          state_n    = LAUNCH;
          byte_n     = mem[rd_ptr];
          transmit_n = 1'b1;
          timer_n    = '0;
        end
      end
      LAUNCH: begin
        if (flush) begin
          // Queue is being cleared: abandon the launch quietly.
          state_n    = IDLE;
          transmit_n = 1'b0;
        end else if (uart_is_transmitting) begin
          state_n    = WAIT_DONE;
          transmit_n = 1'b0;
          pop        = 1'b1;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          // No acknowledge: keep the head and retry from IDLE.
          state_n    = IDLE;
          transmit_n = 1'b0;
          timeout_n  = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      WAIT_DONE: begin
        // transmit stays low so the UART can leave its post-frame recovery.
        transmit_n = 1'b0;
        if (!uart_is_transmitting)
          state_n = IDLE;
      end
      default: begin
        state_n    = IDLE;
        transmit_n = 1'b0;
      end
    endcase
  end

  // Controller state and all UART-facing / status outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      timer         <= '0;
      ack_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      uart_transmit <= transmit_n;
      uart_tx_byte  <= byte_n;
      timer         <= timer_n;
      ack_timeout   <= timeout_n;
      busy          <= (state_n != IDLE) || (count_n != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: a small UART responder, a queue-based
// reference model of the FIFO, a frame scoreboard and directed plus random
// stimulus.
`timescale 1ns/1ps
module tb_uart_tx_queue;
  localparam int DEPTH     = 16;
  localparam int ACK_TO    = 8;
  localparam int FRAME_CYC = 6;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       uart_is_transmitting = 1'b0;
  logic       full, empty, overflow, busy, ack_timeout, uart_transmit;
  logic [7:0] uart_tx_byte;
`ifdef UART_TX_QUEUE_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_tx_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .flush                (flush),
    .full                 (full),
    .empty                (empty),
    .overflow             (overflow),
    .busy                 (busy),
    .ack_timeout          (ack_timeout),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting)
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    .level                (level)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- UART responder ----------------
  // Starts a frame on a rising transmit, reports is_transmitting for
  // FRAME_CYC cycles, then returns idle.
  logic       uart_en = 1'b0;
  int         uart_cnt = 0;
  logic       tx_prev = 1'b0;
  logic       frame_started = 1'b0;
  logic [7:0] frame_byte = 8'h00;

  always @(posedge clk) begin
    frame_started <= 1'b0;
    tx_prev       <= uart_transmit;
    if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_is_transmitting <= 1'b0;
    end else if (uart_en && uart_transmit && !tx_prev) begin
      uart_is_transmitting <= 1'b1;
      uart_cnt             <= FRAME_CYC;
      frame_started        <= 1'b1;
      frame_byte           <= uart_tx_byte;
    end
  end

  // ---------------- reference model ----------------
  // mq holds the bytes the queue should contain; the head leaves one edge
  // after the UART accepted it. exp_q is the list of frames still owed.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       exp_full  = 1'b0;
  logic       exp_empty = 1'b1;
  logic       exp_ovf   = 1'b0;
  int         exp_level = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      exp_full  <= 1'b0;
      exp_empty <= 1'b1;
      exp_ovf   <= 1'b0;
      exp_level <= 0;
    end else begin
      exp_ovf <= wr_en && !flush && (mq.size() == DEPTH);
      if (flush) begin
        mq.delete();
        exp_q.delete();
      end else begin
        if (wr_en && mq.size() < DEPTH) begin
          mq.push_back(wr_data);
          exp_q.push_back(wr_data);
        end
        if (frame_started && mq.size() > 0) mq.delete(0);
      end
      exp_full  <= (mq.size() == DEPTH);
      exp_empty <= (mq.size() == 0);
      exp_level <= mq.size();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int frames_seen   = 0;
  int timeouts_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("full", full, exp_full);
      check("empty", empty, exp_empty);
      check("overflow", overflow, exp_ovf);
      if (!exp_empty) check("busy_nonempty", busy, 1);
`ifdef UART_TX_QUEUE_LEVEL_EN
      check("level", level, exp_level);
`endif
      if (frame_started) begin
        frames_seen <= frames_seen + 1;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL frame_unexpected: got %02h expected no frame", frame_byte);
        end else begin
          check("frame_byte", frame_byte, exp_q.pop_front());
        end
      end
      if (ack_timeout) timeouts_seen <= timeouts_seen + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_frame_start(input string name);
    int n = 0;
    while (!frame_started && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 60, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    uart_en = 1'b1;
    while ((exp_q.size() != 0 || uart_is_transmitting || uart_transmit) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int f0, t0, n;

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_transmit", uart_transmit, 0);
    check("rst_tx_byte", uart_tx_byte, 8'h00);
    check("rst_ack_timeout", ack_timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte: latency and handshake
    uart_en = 1'b1;
    f0 = frames_seen;
    write_byte(8'hA5);                                   // after E0
    check("t1_empty_e0", empty, 0);
    check("t1_tx_low_e0", uart_transmit, 0);
    @(negedge clk);                                      // after E1
    check("t1_tx_high_e1", uart_transmit, 1);
    check("t1_byte_e1", uart_tx_byte, 8'hA5);
    check("t1_busy_e1", busy, 1);
    @(negedge clk);                                      // after E2
    check("t1_tx_high_e2", uart_transmit, 1);
    @(negedge clk);                                      // after E3
    check("t1_tx_low_e3", uart_transmit, 0);
    check("t1_empty_e3", empty, 1);
    drain("t1_drain");
    check("t1_one_frame", frames_seen - f0, 1);
    check("t1_idle_busy", busy, 0);

    // burst of 17 into a stalled UART
    uart_en = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      if (i == 15) check("t2_full_16", full, 1);
      if (i == 16) check("t2_overflow_17", overflow, 1);
    end
    drain("t2_drain");
    check("t2_frames", frames_seen - f0, 16);

    // write while full on the pop cycle
    uart_en = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom));
    check("t3_full", full, 1);
    uart_en = 1'b1;
    wait_frame_start("t3_frame_start");
    write_byte(8'h3C);                                   // lands on the pop edge
    check("t3_overflow", overflow, 1);
    check("t3_full_after", full, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
    check("t3_level", level, 15);
`endif
    drain("t3_drain");
    check("t3_frames", frames_seen - f0, 16);

    // acknowledge timeout and retry
    uart_en = 1'b0;
    t0 = timeouts_seen;
    write_byte(8'h11);
    n = 0;
    while (!uart_transmit && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (uart_transmit && n < 50) begin n++; @(negedge clk); end
    check("t4_high_cycles", n, ACK_TO);
    check("t4_ack_pulse", ack_timeout, 1);
    @(negedge clk);
    check("t4_ack_single", ack_timeout, 0);
    check("t4_relaunch", uart_transmit, 1);
    check("t4_byte_kept", uart_tx_byte, 8'h11);
    check("t4_not_popped", empty, 0);
    drain("t4_drain");
    check("t4_timeout_count", timeouts_seen - t0 >= 1, 1);

    // flush during LAUNCH
    uart_en = 1'b0;
    f0 = frames_seen;
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    check("t5_in_launch", uart_transmit, 1);
    t0 = timeouts_seen;
    do_flush();
    check("t5_tx_low", uart_transmit, 0);
    check("t5_empty", empty, 1);
    check("t5_no_ack", ack_timeout, 0);
    repeat (12) @(negedge clk);
    check("t5_still_low", uart_transmit, 0);
    check("t5_no_timeout", timeouts_seen - t0, 0);
    check("t5_no_frame", frames_seen - f0, 0);

    // flush during WAIT_DONE
    uart_en = 1'b1;
    f0 = frames_seen;
    write_byte(8'h55);
    write_byte(8'h66);
    write_byte(8'h77);
    wait_frame_start("t6_frame_start");
    @(negedge clk);
    do_flush();
    check("t6_empty", empty, 1);
    drain("t6_drain");
    check("t6_one_frame", frames_seen - f0, 1);

    // async reset during WAIT_DONE
    uart_en = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'h88 + 8'(i));
    wait_frame_start("t7_frame_start");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t7_transmit", uart_transmit, 0);
    check("t7_empty", empty, 1);
    check("t7_full", full, 0);
    check("t7_busy", busy, 0);
    check("t7_tx_byte", uart_tx_byte, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames_seen;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uart_transmit) n++;
    end
    check("t7_no_launch", n, 0);
    check("t7_no_frame", frames_seen - f0, 0);
    write_byte(8'h5A);
    drain("t7_drain");
    check("t7_new_frame", frames_seen - f0, 1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      flush   = !uart_transmit && ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) uart_en = ~uart_en;
      @(negedge clk);
    end
    wr_en = 1'b0;
    flush = 1'b0;
    drain("rand_drain");
    check("rand_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
